// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_sequencer
// Brief   : Sequences one operation at a time through an external multi-cycle
//           ALU with a valid/ready request and response handshake.
// Revision: 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [4:0]  alu_ctrl,
    output logic        alu_enable,
    input  logic [31:0] alu_zHI,
    input  logic [31:0] alu_zLOW,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err,
    output logic [15:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_OP_MUL   = 5'd2;
    localparam logic [4:0] c_OP_DIV   = 5'd3;
    localparam logic [4:0] c_OP_LAST  = 5'd11;
    localparam logic [3:0] c_MUL_CNT  = 4'(MUL_LAT - 1);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_LAT - 1);
    localparam logic [3:0] c_ONE_CNT  = 4'd0;

    state_t      r_state_q,     w_state_d;
    logic [3:0]  r_cnt_q,       w_cnt_d;
    logic [31:0] r_alu_a_q,     w_alu_a_d;
    logic [31:0] r_alu_b_q,     w_alu_b_d;
    logic [4:0]  r_alu_ctrl_q,  w_alu_ctrl_d;
    logic        r_alu_en_q,    w_alu_en_d;
    logic        r_req_ready_q, w_req_ready_d;
    logic        r_rsp_valid_q, w_rsp_valid_d;
    logic [31:0] r_rsp_hi_q,    w_rsp_hi_d;
    logic [31:0] r_rsp_lo_q,    w_rsp_lo_d;
    logic        r_rsp_err_q,   w_rsp_err_d;
    logic [15:0] r_ops_done_q,  w_ops_done_d;

    logic        w_accept;
    logic        w_illegal;
    logic [3:0]  w_lat_cnt;

    assign w_accept  = req_valid & r_req_ready_q;
    assign w_illegal = (req_op > c_OP_LAST) || ((req_op == c_OP_DIV) && (req_b == 32'd0));

    always_comb begin
        w_lat_cnt = c_ONE_CNT;
        if (req_op == c_OP_MUL) begin
            w_lat_cnt = c_MUL_CNT;
        end else if (req_op == c_OP_DIV) begin
            w_lat_cnt = c_DIV_CNT;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_alu_a_d     = r_alu_a_q;
        w_alu_b_d     = r_alu_b_q;
        w_alu_ctrl_d  = r_alu_ctrl_q;
        w_alu_en_d    = r_alu_en_q;
        w_req_ready_d = r_req_ready_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_hi_d    = r_rsp_hi_q;
        w_rsp_lo_d    = r_rsp_lo_q;
        w_rsp_err_d   = r_rsp_err_q;
        w_ops_done_d  = r_ops_done_q;

        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    w_req_ready_d = 1'b0;
                    if (w_illegal) begin
                        // Rejected ops never touch the ALU; answer on the next cycle.
                        w_state_d     = DONE;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_hi_d    = 32'd0;
                        w_rsp_lo_d    = 32'd0;
                        w_rsp_err_d   = 1'b1;
                    end else begin
                        w_state_d    = EXEC;
                        w_cnt_d      = w_lat_cnt;
                        w_alu_a_d    = req_a;
                        w_alu_b_d    = req_b;
                        w_alu_ctrl_d = req_op;
                        w_alu_en_d   = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d     = DONE;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_hi_d    = alu_zHI;
                    w_rsp_lo_d    = alu_zLOW;
                    w_rsp_err_d   = 1'b0;
                    w_alu_a_d     = 32'd0;
                    w_alu_b_d     = 32'd0;
                    w_alu_ctrl_d  = 5'd0;
                    w_alu_en_d    = 1'b0;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_d     = IDLE;
                    w_rsp_valid_d = 1'b0;
                    w_req_ready_d = 1'b1;
                    w_ops_done_d  = r_ops_done_q + 16'd1;
                end
            end
            default: begin
                w_state_d     = IDLE;
                w_req_ready_d = 1'b1;
                w_rsp_valid_d = 1'b0;
                w_alu_en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= 4'd0;
            r_alu_a_q     <= 32'd0;
            r_alu_b_q     <= 32'd0;
            r_alu_ctrl_q  <= 5'd0;
            r_alu_en_q    <= 1'b0;
            r_req_ready_q <= 1'b1;
            r_rsp_valid_q <= 1'b0;
            r_rsp_hi_q    <= 32'd0;
            r_rsp_lo_q    <= 32'd0;
            r_rsp_err_q   <= 1'b0;
            r_ops_done_q  <= 16'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_alu_a_q     <= w_alu_a_d;
            r_alu_b_q     <= w_alu_b_d;
            r_alu_ctrl_q  <= w_alu_ctrl_d;
            r_alu_en_q    <= w_alu_en_d;
            r_req_ready_q <= w_req_ready_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_hi_q    <= w_rsp_hi_d;
            r_rsp_lo_q    <= w_rsp_lo_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_ops_done_q  <= w_ops_done_d;
        end
    end

    assign req_ready  = r_req_ready_q;
    assign alu_A      = r_alu_a_q;
    assign alu_B      = r_alu_b_q;
    assign alu_ctrl   = r_alu_ctrl_q;
    assign alu_enable = r_alu_en_q;
    assign rsp_valid  = r_rsp_valid_q;
    assign rsp_hi     = r_rsp_hi_q;
    assign rsp_lo     = r_rsp_lo_q;
    assign rsp_err    = r_rsp_err_q;
    assign ops_done   = r_ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_alu_sequencer
// Brief   : Directed-vector bench with an expected-response queue and monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int c_MUL_LAT = 4;
    localparam int c_DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [4:0]  alu_ctrl;
    logic        alu_enable;
    logic [31:0] alu_zHI;
    logic [31:0] alu_zLOW;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_err;
    logic [15:0] ops_done;

    alu_sequencer #(.MUL_LAT(c_MUL_LAT), .DIV_LAT(c_DIV_LAT)) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_ctrl   (alu_ctrl),
        .alu_enable (alu_enable),
        .alu_zHI    (alu_zHI),
        .alu_zLOW   (alu_zLOW),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hi     (rsp_hi),
        .rsp_lo     (rsp_lo),
        .rsp_err    (rsp_err),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU stub: result is only presented on its final latency cycle.
    function automatic int alu_lat(input logic [4:0] op);
        if (op == 5'd2) return c_MUL_LAT;
        if (op == 5'd3) return c_DIV_LAT;
        return 1;
    endfunction

    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        logic [63:0] aa;
        r  = 64'd0;
        aa = {a, a};
        case (op)
            5'd0:  r = {32'd0, a + b};
            5'd1:  r = {32'd0, a - b};
            5'd2:  r = {32'd0, a} * {32'd0, b};
            5'd3:  r = (b == 32'd0) ? 64'd0 : {a % b, a / b};
            5'd4:  r = {32'd0, a >> b[4:0]};
            5'd5:  r = {32'd0, a << b[4:0]};
            5'd6:  begin aa = aa >> b[4:0]; r = {32'd0, aa[31:0]}; end
            5'd7:  begin aa = aa << b[4:0]; r = {32'd0, aa[63:32]}; end
            5'd8:  r = {32'd0, a & b};
            5'd9:  r = {32'd0, a | b};
            5'd10: r = {32'd0, -a};
            5'd11: r = {32'd0, ~a};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    int en_cnt = 0;
    always @(posedge clk) en_cnt <= alu_enable ? en_cnt + 1 : 0;

    always_comb begin
        alu_zHI  = 32'hDEAD_BEEF;
        alu_zLOW = 32'hBAD0_BAD0;
        if (alu_enable && (en_cnt == alu_lat(alu_ctrl) - 1)) begin
            {alu_zHI, alu_zLOW} = alu_model(alu_ctrl, alu_A, alu_B);
        end
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          first_cyc;
        int          en_exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_done = 16'd0;
    int          en_seen = 0;
    bit          in_rsp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every presented response against the queue head.
    always @(negedge clk) begin
        if (req_ready) en_seen = 0;
        if (alu_enable) en_seen++;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                if (!in_rsp) chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
                in_rsp = !rsp_ready;
            end else begin
                if (!in_rsp) chk("rsp_latency", 64'(cyc), 64'(sb[0].first_cyc));
                in_rsp = 1'b1;
                chk("rsp_hi", {32'd0, rsp_hi}, {32'd0, sb[0].hi});
                chk("rsp_lo", {32'd0, rsp_lo}, {32'd0, sb[0].lo});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, sb[0].err});
                if (rsp_ready) begin
                    chk("enable_cycles", 64'(en_seen), 64'(sb[0].en_exp));
                    void'(sb.pop_front());
                    en_seen = 0;
                    in_rsp  = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input logic err,
                         input int k, input int en);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {63'd0, req_ready}, 64'd1);
            req_valid = 1'b0;
            return;
        end
        e.hi = hi; e.lo = lo; e.err = err; e.first_cyc = cyc + k; e.en_exp = en;
        sb.push_back(e);
        exp_done = exp_done + 16'd1;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 5'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clr       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_op    = 5'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_alu_enable", {63'd0, alu_enable}, 64'd0);
        chk("reset_alu_ctrl", {59'd0, alu_ctrl}, 64'd0);
        chk("reset_alu_ab", {alu_A, alu_B}, 64'd0);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_data", {rsp_hi, rsp_lo}, 64'd0);
        chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("reset_ops_done", {48'd0, ops_done}, 64'd0);
        clr = 1'b0;

        issue(5'd0,  32'd5,          32'd7,          32'd0, 32'd12,         1'b0, 2, 1);
        issue(5'd2,  32'h0001_0000,  32'h0001_0000,  32'd1, 32'd0,          1'b0, 5, 4);
        issue(5'd3,  32'd9,          32'd0,          32'd0, 32'd0,          1'b1, 1, 0);
        issue(5'd20, 32'd5,          32'd7,          32'd0, 32'd0,          1'b1, 1, 0);
        issue(5'd12, 32'd5,          32'd7,          32'd0, 32'd0,          1'b1, 1, 0);
        issue(5'd1,  32'd10,         32'd3,          32'd0, 32'd7,          1'b0, 2, 1);
        issue(5'd1,  32'd3,          32'd5,          32'd0, 32'hFFFF_FFFE,  1'b0, 2, 1);
        issue(5'd4,  32'h8000_0000,  32'd4,          32'd0, 32'h0800_0000,  1'b0, 2, 1);
        issue(5'd5,  32'd1,          32'd31,         32'd0, 32'h8000_0000,  1'b0, 2, 1);
        issue(5'd6,  32'd1,          32'd1,          32'd0, 32'h8000_0000,  1'b0, 2, 1);
        issue(5'd7,  32'h8000_0001,  32'd4,          32'd0, 32'h0000_0018,  1'b0, 2, 1);
        issue(5'd8,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0, 32'hF000_F000,  1'b0, 2, 1);
        issue(5'd9,  32'h0F0F_0000,  32'h0000_00F0,  32'd0, 32'h0F0F_00F0,  1'b0, 2, 1);
        issue(5'd10, 32'd1,          32'd0,          32'd0, 32'hFFFF_FFFF,  1'b0, 2, 1);
        issue(5'd11, 32'h1234_5678,  32'd0,          32'd0, 32'hEDCB_A987,  1'b0, 2, 1);
        issue(5'd2,  32'hFFFF_FFFF,  32'd2,          32'd1, 32'hFFFF_FFFE,  1'b0, 5, 4);
        issue(5'd3,  32'd100,        32'd7,          32'd2, 32'd14,         1'b0, 9, 8);
        issue(5'd3,  32'd7,          32'd100,        32'd7, 32'd0,          1'b0, 9, 8);
        wait_idle();
        chk("ops_done_vectors", {48'd0, ops_done}, {48'd0, exp_done});

        // Hold the response under backpressure.
        @(posedge clk); #1 rsp_ready = 1'b0;
        issue(5'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 9, 8);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", {63'd0, rsp_valid}, 64'd1);
        repeat (5) begin
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_ops_done", {48'd0, ops_done}, {48'd0, exp_done - 16'd1});
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_idle();
        chk("bp_ops_done_release", {48'd0, ops_done}, {48'd0, exp_done});

        // Reset while a divide is in flight.
        @(negedge clk);
        req_valid = 1'b1; req_op = 5'd3; req_a = 32'd100; req_b = 32'd7;
        chk("rst_pre_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_exec_enable", {63'd0, alu_enable}, 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_done = 16'd0;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_ops_done", {48'd0, ops_done}, 64'd0);
        chk("rst_alu_enable", {63'd0, alu_enable}, 64'd0);
        chk("rst_alu_ctrl", {59'd0, alu_ctrl}, 64'd0);
        repeat (15) @(negedge clk);
        chk("rst_no_rsp_ops_done", {48'd0, ops_done}, 64'd0);
        issue(5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 2, 1);
        wait_idle();
        chk("rst_recover_ops_done", {48'd0, ops_done}, 64'd1);

        // Preload the completion counter near its wrap point.
        @(negedge clk);
        force dut.r_ops_done_q = 16'hFFFD;
        #1 release dut.r_ops_done_q;
        exp_done = 16'hFFFD;
        chk("wrap_preload", {48'd0, ops_done}, 64'hFFFD);
        issue(5'd11, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 2, 1);
        issue(5'd11, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 2, 1);
        issue(5'd31, 32'd0, 32'd0, 32'd0, 32'd0,         1'b1, 1, 0);
        wait_idle();
        chk("wrap_ops_done", {48'd0, ops_done}, 64'h0000);
        issue(5'd11, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b0, 2, 1);
        wait_idle();
        chk("wrap_ops_done_next", {48'd0, ops_done}, {48'd0, exp_done});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles the ALU needs to produce a valid multiply result; legal range 1-15.
REQ-002 Parameter DIV_LAT, default 8: cycles the ALU needs to produce a valid divide result; legal range 1-15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  requester presents an operation.
REQ-006 req_ready  output  1  sequencer accepts an operation this cycle.
REQ-007 req_op  input  5  ALU control code (0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not).
REQ-008 req_a, req_b  input  32 each  operands.
REQ-009 alu_A, alu_B  output  32 each  operands driven to the ALU.
REQ-010 alu_ctrl  output  5  control code driven to the ALU.
REQ-011 alu_enable  output  1  high while an ALU operation is in flight.
REQ-012 alu_zHI, alu_zLOW  input  32 each  ALU result halves.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts the result.
REQ-015 rsp_hi, rsp_lo  output  32 each  captured result (remainder/quotient for div, upper/lower product for mul).
REQ-016 rsp_err  output  1  result is an error (illegal op or divide by zero).
REQ-017 ops_done  output  16  count of completed response handshakes.

Function
REQ-018 The FSM SHALL have states IDLE, EXEC, DONE; req_ready=1 only in IDLE.
REQ-019 Accept = req_valid & req_ready at edge T; operands and op latched into internal registers at T.
REQ-020 Legal accepted op (0-11, not div-by-zero): IDLE->EXEC; down-counter loaded with latency-1, latency = MUL_LAT for op 2, DIV_LAT for op 3, 1 otherwise.
REQ-021 In EXEC: alu_A/alu_B/alu_ctrl SHALL equal the latched values, held stable; alu_enable=1; counter decrements each cycle.
REQ-022 In EXEC with counter==0: alu_zHI->rsp_hi, alu_zLOW->rsp_lo, rsp_err=0, state->DONE at that edge.
REQ-023 Resulting latency: rsp_valid first high at T+1+latency (single-cycle op: T+2; default mul: T+5; default div: T+9).
REQ-024 req_op>11 or (op 3 with req_b==0): IDLE->DONE directly; rsp_hi=rsp_lo=0, rsp_err=1, rsp_valid high at T+1; alu_enable stays 0.
REQ-025 rsp_valid=1 exactly in DONE; rsp_hi/rsp_lo/rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-026 DONE with rsp_ready=1: state->IDLE, ops_done+1; new request cannot be accepted in that same cycle (req_ready=0 in DONE).
REQ-027 ops_done SHALL wrap 0xFFFF->0x0000; counts error responses too.
REQ-028 Outside EXEC: alu_enable=0, alu_ctrl=0, alu_A=alu_B=0.
REQ-029 req_valid deasserted or changing while req_ready=0 SHALL have no effect; inputs sampled only at accept.
REQ-030 alu_zHI/alu_zLOW SHALL be ignored in every cycle except the capture cycle of REQ-022.

Reset
REQ-031 clr=1 at an edge, from any state: state->IDLE, counter=0, latched op/operands=0, rsp_valid=0, rsp_hi=rsp_lo=0, rsp_err=0, ops_done=0.
REQ-032 Outputs after reset: req_ready=1, alu_enable=0, alu_ctrl=0, alu_A=alu_B=0.
REQ-033 clr mid-EXEC or in DONE SHALL discard the in-flight operation with no response and no ops_done increment; clr overrides a simultaneous accept or response handshake.

Verification
REQ-034 add: accept op 0, a=5, b=7 at T, rsp_ready=1 -> rsp_valid at T+2, rsp_lo=12, rsp_hi=0, rsp_err=0, ops_done=1.
REQ-035 mul (MUL_LAT=4): op 2, a=0x10000, b=0x10000 -> alu_enable high T+1..T+4, rsp_valid at T+5, rsp_hi=1, rsp_lo=0.
REQ-036 div by zero and illegal: op 3, b=0 -> rsp_valid at T+1, rsp_err=1, rsp_hi=rsp_lo=0, alu_enable never high; repeat with op 20 -> same response.
REQ-037 backpressure: div 100/7 with rsp_ready=0 for 5 cycles after rsp_valid -> rsp_lo=14, rsp_hi=2 held stable, req_ready=0 throughout, single ops_done increment on release.
REQ-038 reset mid-op: clr during EXEC of a div -> next cycle IDLE, req_ready=1, rsp_valid=0, no response ever issued, ops_done=0.
REQ-039 wrap: preload via 65536 back-to-back op-11 responses -> ops_done returns to 0x0000.
